// File: rtl/q_route_pkg.sv
// Shared routing-node definitions: word width, node-memory map, sentinels and
// the candidate-scan state encodings also used by the policy block.
package q_route_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [WORD_WIDTH-1:0] TABLE_BASE = 16'h0700;
  localparam logic [WORD_WIDTH-1:0] LIST_BASE  = 16'h0710;
  localparam logic [WORD_WIDTH-1:0] LEN_ADDR   = 16'h0720;

  // NO_HOP stands for "-1" in the node's hop-ID space.
  localparam logic [WORD_WIDTH-1:0] NO_HOP = 16'd100;
  localparam logic [WORD_WIDTH-1:0] Q_INF  = 16'hFFFF;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'd0,
    ST_RD_ID  = 8'd1,
    ST_RD_Q   = 8'd2,
    ST_RD_ORG = 8'd3,
    ST_EVAL   = 8'd4,
    ST_WR_LEN = 8'd5,
    ST_DONE   = 8'd6
  } scan_state_t;

endpackage

// File: rtl/q_candidate_scan_if.sv
// Bus between the candidate scanner and its environment: control handshake,
// node-memory port and the best-entry results.
interface q_candidate_scan_if;
  import q_route_pkg::*;

  // start_scan is sampled only while the scanner is idle; done_scan is a
  // single-cycle pulse once the list and its length are in memory. Memory
  // reads return data_in the cycle after address is presented; a write
  // happens on every cycle in which wr_en is high.
  logic                  start_scan;
  logic [WORD_WIDTH-1:0] num_neighbors;
  logic [WORD_WIDTH-1:0] mybest;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] besthop;
  logic [WORD_WIDTH-1:0] bestvalue;
  logic [WORD_WIDTH-1:0] bestneighborID;
  logic                  done_scan;
  logic [7:0]            cstate;

  modport master (
    output start_scan, num_neighbors, mybest, data_in,
    input  address, data_out, wr_en, besthop, bestvalue, bestneighborID,
           done_scan, cstate
  );

  modport slave (
    input  start_scan, num_neighbors, mybest, data_in,
    output address, data_out, wr_en, besthop, bestvalue, bestneighborID,
           done_scan, cstate
  );

endinterface

// File: rtl/q_candidate_scan.sv
// Scans the neighbour Q-table, tracks the best entry and writes the list of
// hops better than mybest. Define SCAN_TIE_LAST_EN to let equal Q-values pick the later entry.
module q_candidate_scan
  import q_route_pkg::*;
#(
  parameter int MAX_NEIGHBORS = 8
) (
  input logic              clock,
  input logic              nreset,
  q_candidate_scan_if.slave bus
);

  localparam logic [4:0] MAX_N = 5'(MAX_NEIGHBORS);

  scan_state_t           state;
  logic [4:0]            n_lat;
  logic [4:0]            idx;
  logic [4:0]            count;
  logic [WORD_WIDTH-1:0] hop_r;
  logic [WORD_WIDTH-1:0] q_r;
  logic [WORD_WIDTH-1:0] address_r;
  logic [WORD_WIDTH-1:0] data_out_r;
  logic                  wr_en_r;
  logic [WORD_WIDTH-1:0] besthop_r;
  logic [WORD_WIDTH-1:0] bestvalue_r;
  logic [WORD_WIDTH-1:0] bestnbr_r;
  logic                  done_r;

  logic [4:0] n_clamped;
  logic [4:0] idx_nxt;
  logic       take_best;
  logic       take_cand;

  always_comb begin
    n_clamped = MAX_N;
    if (bus.num_neighbors < WORD_WIDTH'(MAX_NEIGHBORS)) begin
      n_clamped = bus.num_neighbors[4:0];
    end
  end

  assign idx_nxt = idx + 5'd1;

  // Q_INF can never win: strict compare against the reset value excludes it,
  // and the tie-last variant excludes it explicitly.
`ifdef SCAN_TIE_LAST_EN
  assign take_best = (q_r <= bestvalue_r) && (q_r != Q_INF);
`else
  assign take_best = (q_r < bestvalue_r);
`endif
  assign take_cand = (q_r < bus.mybest);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      n_lat       <= '0;
      idx         <= '0;
      count       <= '0;
      hop_r       <= '0;
      q_r         <= '0;
      address_r   <= '0;
      data_out_r  <= '0;
      wr_en_r     <= 1'b0;
      besthop_r   <= NO_HOP;
      bestvalue_r <= Q_INF;
      bestnbr_r   <= NO_HOP;
      done_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          if (bus.start_scan) begin
            n_lat       <= n_clamped;
            idx         <= '0;
            count       <= '0;
            besthop_r   <= NO_HOP;
            bestvalue_r <= Q_INF;
            bestnbr_r   <= NO_HOP;
            state       <= (n_clamped == 5'd0) ? ST_WR_LEN : ST_RD_ID;
          end
        end
        ST_RD_ID: begin
          wr_en_r   <= 1'b0;
          address_r <= TABLE_BASE + WORD_WIDTH'({idx, 2'b00});
          state     <= ST_RD_Q;
        end
        ST_RD_Q: begin
          hop_r     <= bus.data_in;
          address_r <= address_r + 16'd1;
          state     <= ST_RD_ORG;
        end
        ST_RD_ORG: begin
          q_r       <= bus.data_in;
          address_r <= address_r + 16'd1;
          state     <= ST_EVAL;
        end
        ST_EVAL: begin
          // data_in carries the originator word requested in RD_ORG.
          if (take_best) begin
            besthop_r   <= hop_r;
            bestvalue_r <= q_r;
            bestnbr_r   <= bus.data_in;
          end
          if (take_cand) begin
            address_r  <= LIST_BASE + WORD_WIDTH'(count);
            data_out_r <= hop_r;
            wr_en_r    <= 1'b1;
            count      <= count + 5'd1;
          end
          idx   <= idx_nxt;
          state <= (idx_nxt == n_lat) ? ST_WR_LEN : ST_RD_ID;
        end
        ST_WR_LEN: begin
          address_r  <= LEN_ADDR;
          data_out_r <= WORD_WIDTH'(count);
          wr_en_r    <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.address        = address_r;
  assign bus.data_out       = data_out_r;
  assign bus.wr_en          = wr_en_r;
  assign bus.besthop        = besthop_r;
  assign bus.bestvalue      = bestvalue_r;
  assign bus.bestneighborID = bestnbr_r;
  assign bus.done_scan      = done_r;
  assign bus.cstate         = state;

endmodule

// File: doc/q_candidate_scan.md
Name: q_candidate_scan

Overview:
- Routing-node stage directly upstream of the winner/next-hop policy block.
- On start, scans the neighbour Q-table in shared node memory and finds the best (lowest) Q-value, its hop and its originating neighbour.
- Writes the list of "better" candidate hops (Q < mybest) and the list length to memory, where the policy stage reads them.
- Pulses done so the policy stage can be started.

Parameters:
- WORD_WIDTH, 16, data/address width.
- MAX_NEIGHBORS, 8, table entries scanned at most; must be ≤16.
- TABLE_BASE, 16'h700, first Q-table word.
- LIST_BASE, 16'h710, candidate-list base (16 words).
- LEN_ADDR, 16'h720, candidate-list length word.
- NO_HOP, 100, "no hop" sentinel (stands for −1).

Ports:
- clock  in  1  system clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- start_scan  in  1  start request, sampled in IDLE only.
- num_neighbors  in  16  valid table entries.
- mybest  in  16  node's current best Q, the threshold for candidates.
- data_in  in  16  memory read data, valid the cycle after address.
- address  out  16  memory address.
- data_out  out  16  memory write data.
- wr_en  out  1  memory write strobe.
- besthop  out  16  hop ID of the best entry.
- bestvalue  out  16  best (minimum) Q-value.
- bestneighborID  out  16  originator ID of the best entry.
- done_scan  out  1  one-cycle completion pulse.
- cstate  out  8  current state, for debug.

Behaviour:
- Reset: nreset low clears all registers immediately, independent of clock.
  - address=0, data_out=0, wr_en=0, done_scan=0.
  - besthop=NO_HOP, bestvalue=16'hFFFF, bestneighborID=NO_HOP, state=IDLE.
  - Reset mid-scan abandons the scan; partial list writes remain in memory; LEN_ADDR is not updated.
- Table layout: entry i occupies TABLE_BASE+4i. Word 0 = hop ID, word 1 = Q-value, word 2 = originator ID, word 3 unused.
- All compares are unsigned 16-bit; lower Q is better.
- States (cstate encoding): IDLE=0, RD_ID=1, RD_Q=2, RD_ORG=3, EVAL=4, WR_LEN=5, DONE=6.
- IDLE:
  - Outputs hold their last results.
  - On start_scan=1: latch N=min(num_neighbors, MAX_NEIGHBORS).
  - Clear i, count, besthop, bestvalue, bestneighborID to reset values.
  - Go to RD_ID, or to WR_LEN if N=0.
- RD_ID: address=TABLE_BASE+4i.
- RD_Q: capture hop ID; address=+1.
- RD_ORG: capture Q; address=+2.
- EVAL: capture originator.
  - If Q < bestvalue: update all three best outputs. Ties keep the earlier entry.
  - If Q < mybest: address=LIST_BASE+count, data_out=hop ID, wr_en=1 for this cycle, count++.
  - i++. If i==N go to WR_LEN, else RD_ID.
- WR_LEN: address=LEN_ADDR, data_out=count, wr_en=1 for one cycle.
- DONE: done_scan=1 for exactly one cycle, then IDLE.
- Latency: done_scan is high in cycle 4N+3 after the clock edge that samples start_scan.
- wr_en is never high outside EVAL and WR_LEN.
- start_scan is ignored outside IDLE. start_scan held high re-triggers a scan on the cycle after DONE.
- count never exceeds MAX_NEIGHBORS, so list writes stay within LIST_BASE..LIST_BASE+15.
- Entry with Q=16'hFFFF never becomes best; with all entries at 16'hFFFF, best outputs stay at their reset values.
- mybest=0 gives an empty list (count=0), but the best outputs are still computed.

Optional Feature:
- SCAN_TIE_LAST_EN
  - Defined: the best update uses Q ≤ bestvalue, so ties select the later entry. The Q=16'hFFFF exclusion still applies.
  - Undefined: strict <, first entry wins.
  - List contents and count are identical in both builds.

Decomposition:
- Shared package q_route_pkg holds:
  - WORD_WIDTH.
  - TABLE_BASE, LIST_BASE, LEN_ADDR.
  - NO_HOP, and Q_INF=16'hFFFF.
  - State encodings, shared with the policy block's memory map.
- No sub-module: one FSM with a single comparator pair; splitting adds nothing.

Test Plan:
- Table {(2,40,2),(5,25,9),(7,30,7)}, N=3, mybest=35 -> besthop=5, bestvalue=25, bestneighborID=9; mem[0x710]=5, mem[0x711]=7, mem[0x720]=2; done_scan at cycle 15.
- N=0 -> single write mem[0x720]=0; besthop=100, bestvalue=FFFF; done_scan at cycle 3.
- Entries {(3,20,3),(4,20,6)}, mybest=10 -> besthop=3 (besthop=4 with SCAN_TIE_LAST_EN); mem[0x720]=0.
- num_neighbors=12 with 12 table entries, all Q=5, mybest=9 -> exactly 8 entries read; mem[0x710..0x717] written; mem[0x720]=8; no access at ≥0x720 other than the length word.
- nreset low during EVAL of entry 1 -> wr_en and all outputs return to reset values immediately; mem[0x720] unchanged; a fresh start completes normally.
- start_scan pulsed during RD_Q -> ignored; exactly one done_scan pulse results.
